// File: rtl/eth_frame_gate.sv
// Receive-side frame gate: holds aggregated words until the checksum unit passes the frame,
// then releases them downstream; failed or overflowing frames are rewound and counted.
module eth_frame_gate #(
    parameter int DEPTH = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        axiiv,
    input  logic [31:0] axiid,
    input  logic        done,
    input  logic        kill,
    input  logic        axior,
    output logic        axiov,
    output logic [31:0] axiod,
    output logic        axiol,
    output logic [13:0] good_count,
    output logic [7:0]  drop_count,
    output logic        overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CAP = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE = (AW+1)'(1);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        DROP
    } state_t;

    state_t state, state_nx;

    logic [AW:0]      wr_ptr, commit_ptr, rd_ptr;
    logic [31:0]      mem [DEPTH];
    logic [DEPTH-1:0] last_bits;

    logic done_q, rst_q, done_rise, full;
    logic do_write, do_commit, do_rewind, do_ovf, do_empty;

    // rst_q masks the first cycle after reset so a done level held across reset is not an edge.
    assign done_rise = done & ~done_q & ~rst_q;
    assign full      = (wr_ptr - rd_ptr) == CAP;

    assign axiov = (rd_ptr != commit_ptr);
    assign axiod = mem[rd_ptr[AW-1:0]];
    assign axiol = last_bits[rd_ptr[AW-1:0]];

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nx  = state;
        do_write  = 1'b0;
        do_commit = 1'b0;
        do_rewind = 1'b0;
        do_ovf    = 1'b0;
        do_empty  = 1'b0;
        case (state)
            IDLE, RECV: begin
                if (axiiv) begin
                    if (full) do_ovf = 1'b1;
                    else      do_write = 1'b1;
                end
                if (done_rise) begin
                    state_nx = IDLE;
                    if (state == IDLE && !axiiv) do_empty = 1'b1;
                    else if (do_ovf || kill)     do_rewind = 1'b1;
                    else                         do_commit = 1'b1;
                end else if (do_ovf) begin
                    state_nx = DROP;
                end else if (do_write) begin
                    state_nx = RECV;
                end
            end
            DROP: begin
                if (done_rise) begin
                    do_rewind = 1'b1;
                    state_nx  = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            commit_ptr <= '0;
            rd_ptr     <= '0;
            done_q     <= 1'b0;
            rst_q      <= 1'b1;
            good_count <= '0;
            drop_count <= '0;
            overflow   <= 1'b0;
        end else begin
            done_q   <= done;
            rst_q    <= 1'b0;
            overflow <= do_ovf;

            if (do_rewind)     wr_ptr <= commit_ptr;
            else if (do_write) wr_ptr <= wr_ptr + ONE;

            // A word arriving on the done edge belongs to the frame being committed.
            if (do_commit) commit_ptr <= wr_ptr + {{AW{1'b0}}, do_write};

            if (axiov && axior) rd_ptr <= rd_ptr + ONE;

            if (do_commit || do_empty) good_count <= good_count + 14'd1;
            if (do_rewind && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
        end
    end

    // NOTE: storage is not reset; the pointers alone define which entries are meaningful.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr[AW-1:0]]       <= axiid;
            last_bits[wr_ptr[AW-1:0]] <= do_commit;
        end else if (do_commit) begin
            last_bits[wr_ptr[AW-1:0] - AW'(1)] <= 1'b1;
        end
    end

endmodule

// File: doc/eth_frame_gate.md
ETH_FRAME_GATE -- requirements
Module: eth_frame_gate

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning buffer capacity in 32-bit words (power of two, >=4).
REQ-002 SHALL have port clk input 1: single clock (50 MHz Ethernet reference clock domain).
REQ-003 SHALL have port rst input 1: reset, synchronous and active-high.
REQ-004 SHALL have port axiiv input 1: aggregated word valid from the aggregator.
REQ-005 SHALL have port axiid input 32: aggregated word data.
REQ-006 SHALL have port done input 1: checksum-unit end-of-frame flag, level-held.
REQ-007 SHALL have port kill input 1: checksum-unit FCS-failure flag, valid when done rises.
REQ-008 SHALL have port axior input 1: downstream ready.
REQ-009 SHALL have port axiov output 1: committed word available.
REQ-010 SHALL have port axiod output 32: committed word data.
REQ-011 SHALL have port axiol output 1: current output word is last of its frame.
REQ-012 SHALL have port good_count output 14: committed frames, wraps.
REQ-013 SHALL have port drop_count output 8: dropped frames, saturates at 255.
REQ-014 SHALL have port overflow output 1: one-cycle pulse when a frame is abandoned for lack of space.

Function
REQ-015 SHALL hold a DEPTH-entry word array plus per-entry last bit; wr_ptr, commit_ptr, rd_ptr each log2(DEPTH)+1 bits, compared modulo 2*DEPTH.
REQ-016 SHALL detect end-of-frame as done_rise = done & ~done_q, done_q registered each cycle.
REQ-017 SHALL implement states IDLE, RECV, DROP.
REQ-018 IDLE: axiiv -> write word, enter RECV; done_rise with no word -> empty frame, good_count+1, stay IDLE.
REQ-019 RECV: axiiv and not full -> write mem[wr_ptr], wr_ptr+1; axiiv and full (wr_ptr-rd_ptr==DEPTH) -> word discarded, overflow pulse, enter DROP.
REQ-020 RECV, done_rise & ~kill: commit_ptr <= wr_ptr (including a word written same cycle), last bit set on final word, good_count+1, enter IDLE.
REQ-021 RECV, done_rise & kill: wr_ptr <= commit_ptr, drop_count+1 (saturating), enter IDLE.
REQ-022 DROP: ignore axiiv; on done_rise: wr_ptr <= commit_ptr, drop_count+1 regardless of kill, enter IDLE.
REQ-023 axiov SHALL be 1 iff rd_ptr != commit_ptr; axiod/axiol combinationally from mem[rd_ptr]; rd_ptr+1 when axiov & axior.
REQ-024 Output SHALL be independent of write side; uncommitted words never appear on axiov.
REQ-025 Same-cycle read and write/commit/rewind SHALL all take effect; full computed from pre-update pointers.
REQ-026 Latency: a committed word SHALL be visible on axiov the cycle after done_rise.
REQ-027 axiov SHALL not depend on axior (no combinational ready->valid path).
REQ-028 last bit of a reused entry SHALL be cleared when the entry is written.

Reset
REQ-029 rst SHALL force state IDLE, all pointers 0, done_q 0, good_count 0, drop_count 0, overflow 0, axiov 0; buffered and in-flight frames discarded.
REQ-030 rst mid-frame SHALL not count the frame; a done level still high after reset SHALL not produce done_rise.

Verification
REQ-031 3 words A,B,C, done rises kill=0, axior=1 -> axiod A,B,C on consecutive cycles starting cycle after done, axiol only with C, good_count=1.
REQ-032 2 words, done rises kill=1 -> axiov stays 0, drop_count=1, next good frame output starts at its own first word.
REQ-033 DEPTH=64, axior=0, 65-word frame -> overflow pulse on word 65, frame dropped at done, drop_count=1, axiov=0.
REQ-034 Frame 1 committed, axior=0, frame 2 arriving -> frame 1 words held, frame 2 invisible until its done; both drain in order with two axiol pulses.
REQ-035 rst asserted after 5 words of a frame while done held high -> all counts 0, axiov 0, no commit after rst release.
REQ-036 drop_count at 255, another killed frame -> stays 255; good_count 16383 + one good frame -> 0.
